ext_mem_arb: RTL

EXT_MEM_ARB -- requirements
Module: ext_mem_arb

---
 rtl/ext_mem_arb.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ext_mem_arb.sv
// Arbitrates N native masters onto one external-memory slave port and
// sequences downstream cache invalidates between transactions.
module ext_mem_arb #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS-1:0]            m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
    output logic [N_MASTERS*DATA_W-1:0]     m_rdata,
    output logic [N_MASTERS-1:0]            m_ready,
    output logic                            s_valid,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    output logic [DATA_W/8-1:0]             s_wstrb,
    input  logic [DATA_W-1:0]               s_rdata,
    input  logic                            s_ready,
    input  logic                            inv_req,
    output logic                            force_inv,
    output logic                            inv_busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        INV  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   grant_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic               inv_pend_reg;

    logic [ADDR_W-1:0]  addr_arr  [N_MASTERS];
    logic [DATA_W-1:0]  wdata_arr [N_MASTERS];
    logic [STRB_W-1:0]  wstrb_arr [N_MASTERS];

    logic               busy;
    logic [IDX_W-1:0]   search_start;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    // Outputs are held quiet while reset is asserted, before the first edge.
    assign busy = rst && (state_reg == BUSY);

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_slice
            assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
            assign wstrb_arr[gi] = m_wstrb[gi*STRB_W +: STRB_W];
            assign m_ready[gi]   = busy && s_ready && (grant_reg == IDX_W'(gi));
        end
    endgenerate

    assign m_rdata = {N_MASTERS{s_rdata}};

    // Scan from the highest offset down so the lowest offset from the start wins.
    always_comb begin
        pick_idx     = '0;
        pick_found   = 1'b0;
        cand         = '0;
        search_start = (PRIO_MODE == 1) ? '0 : rr_ptr_reg;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            cand = {1'b0, search_start} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_MASTERS)) begin
                cand = cand - (IDX_W+1)'(N_MASTERS);
            end
            if (m_valid[cand[IDX_W-1:0]]) begin
                pick_idx   = cand[IDX_W-1:0];
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            rr_ptr_reg   <= '0;
            inv_pend_reg <= 1'b0;
        end else begin
            // The INV cycle consumes the pending request; a new one re-arms it.
            inv_pend_reg <= (state_reg == INV) ? inv_req : (inv_pend_reg | inv_req);
            case (state_reg)
                IDLE: begin
                    if (inv_pend_reg) begin
                        state_reg <= INV;
                    end else if (pick_found) begin
                        grant_reg <= pick_idx;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ready) begin
                        state_reg  <= IDLE;
                        rr_ptr_reg <= (grant_reg == IDX_W'(N_MASTERS - 1)) ? '0 : grant_reg + 1'b1;
                    end else if (!m_valid[grant_reg]) begin
                        state_reg <= IDLE;
                    end
                end
                INV: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign s_valid   = busy && m_valid[grant_reg];
    assign s_addr    = busy ? addr_arr[grant_reg]  : '0;
    assign s_wdata   = busy ? wdata_arr[grant_reg] : '0;
    assign s_wstrb   = busy ? wstrb_arr[grant_reg] : '0;
    assign force_inv = rst && (state_reg == INV);
    assign inv_busy  = rst && (inv_pend_reg || (state_reg == INV));

endmodule
